// File: rtl/instr_rom.sv
// UART-loaded 256x16 instruction memory: 8N1 bytes are paired into instructions and
// written from address 0; the CPU reads through a registered synchronous port.
module instr_rom #(
   parameter int unsigned CLK_FREQ  = 100_000_000,
   parameter int unsigned BAUD      = 115_200,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned IDLE_BITS = 10
) (
   input  logic              i_clk_uart,
   input  logic              i_rst,
   input  logic              i_rx,
   input  logic [ADDR_W-1:0] i_addr_read,
   output logic [DATA_W-1:0] o_instr_read,
   output logic              o_instr_transmit_done,
   output logic [ADDR_W-1:0] o_max_addr
);

   localparam int unsigned CPB        = CLK_FREQ / BAUD;
   localparam int unsigned HALF       = CPB / 2;
   localparam int unsigned IDLE_TICKS = IDLE_BITS * CPB;
   localparam int unsigned CNT_W      = $clog2(CPB + 1);
   localparam int unsigned IDLE_W     = $clog2(IDLE_TICKS + 1);
   localparam int unsigned DEPTH      = 2 ** ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_ERR
   } state_t;

   logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

   logic              rx_meta_q, rx_sync_q;
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              byte_vld_q, byte_vld_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic [7:0]        hi_q, hi_d;
   logic              have_hi_q, have_hi_d;
   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic              full_q, full_d;
   logic              written_q, written_d;
   logic              done_q, done_d;
   logic [ADDR_W-1:0] max_q, max_d;
   logic [DATA_W-1:0] rd_q, rd_d;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      byte_vld_d = 1'b0;
      idle_d     = idle_q;
      hi_d       = hi_q;
      have_hi_d  = have_hi_q;
      wptr_d     = wptr_q;
      full_d     = full_q;
      written_d  = written_q;
      done_d     = done_q;
      max_d      = max_q;
      mem_we     = 1'b0;
      mem_wdata  = {hi_q, shift_q};
      rd_d       = mem_q[i_addr_read];

      case (state_q)
         S_IDLE: begin
            if (!done_q && !rx_sync_q) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end
         S_START: begin
            if (cnt_q == CNT_W'(HALF - 1)) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_sync_q ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == CNT_W'(CPB - 1)) begin
               cnt_d   = '0;
               shift_d = {rx_sync_q, shift_q[7:1]};
               if (bit_q == 3'd7) state_d = S_STOP;
               else               bit_d   = bit_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (cnt_q == CNT_W'(CPB - 1)) begin
               cnt_d = '0;
               if (rx_sync_q) begin
                  byte_vld_d = 1'b1;
                  state_d    = S_IDLE;
               end else begin
                  state_d = S_ERR;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_ERR:   if (rx_sync_q) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // shift_q still holds the received byte on the cycle after byte_vld_q
      if (byte_vld_q) begin
         if (!have_hi_q) begin
            hi_d      = shift_q;
            have_hi_d = 1'b1;
         end else begin
            have_hi_d = 1'b0;
            if (!full_q) begin
               mem_we    = 1'b1;
               max_d     = wptr_q;
               written_d = 1'b1;
               if (wptr_q == '1) full_d = 1'b1;
               else              wptr_d = wptr_q + 1'b1;
            end
         end
      end

      if (state_q == S_IDLE && rx_sync_q && !done_q) begin
         if (idle_q != IDLE_W'(IDLE_TICKS)) idle_d = idle_q + 1'b1;
         if (idle_q >= IDLE_W'(IDLE_TICKS - 1) && written_q) begin
            done_d    = 1'b1;
            have_hi_d = 1'b0;
         end
      end else begin
         idle_d = '0;
      end
   end

   always_ff @(posedge i_clk_uart) begin
      if (i_rst) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         byte_vld_q <= 1'b0;
         idle_q     <= '0;
         hi_q       <= '0;
         have_hi_q  <= 1'b0;
         wptr_q     <= '0;
         full_q     <= 1'b0;
         written_q  <= 1'b0;
         done_q     <= 1'b0;
         max_q      <= '0;
         rd_q       <= '0;
      end else begin
         rx_meta_q  <= i_rx;
         rx_sync_q  <= rx_meta_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         byte_vld_q <= byte_vld_d;
         idle_q     <= idle_d;
         hi_q       <= hi_d;
         have_hi_q  <= have_hi_d;
         wptr_q     <= wptr_d;
         full_q     <= full_d;
         written_q  <= written_d;
         done_q     <= done_d;
         max_q      <= max_d;
         rd_q       <= rd_d;
      end
   end

   // Memory is not reset; a pending pair write is suppressed when reset is asserted
   always_ff @(posedge i_clk_uart) begin
      if (mem_we && !i_rst) mem_q[wptr_q] <= mem_wdata;
   end

   assign o_instr_read          = rd_q;
   assign o_instr_transmit_done = done_q;
   assign o_max_addr            = max_q;

endmodule

// File: tb/tb_instr_rom.sv
// Scoreboard bench for instr_rom: stimulus pushes expected responses, a negedge
// monitor pops and compares them; done rises are matched against a second queue.
module tb_instr_rom;

   localparam int CPB = 8;
   localparam int IDLE_TICKS = 10 * CPB;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx;
   logic [7:0]  addr;
   logic [15:0] o_instr_read;
   logic        o_done;
   logic [7:0]  o_max_addr;

   instr_rom #(
      .CLK_FREQ (80),
      .BAUD     (10),
      .ADDR_W   (8),
      .DATA_W   (16),
      .IDLE_BITS(10)
   ) dut (
      .i_clk_uart           (clk),
      .i_rst                (rst),
      .i_rx                 (rx),
      .i_addr_read          (addr),
      .o_instr_read         (o_instr_read),
      .o_instr_transmit_done(o_done),
      .o_max_addr           (o_max_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          kind;
      int          a;
      logic [15:0] exp;
   } chk_t;

   chk_t        chk_q[$];
   int          done_q[$];
   int          n_vec = 0;
   int          n_miss = 0;
   int unsigned cyc = 0;
   int unsigned mark = 0;
   logic        chk_vld = 1'b0;
   logic        chk_vld_d = 1'b0;
   logic        done_prev = 1'b0;

   always @(posedge clk) begin
      cyc       <= cyc + 1;
      chk_vld_d <= chk_vld;
   end

   // Monitor: kind 0 = o_instr_read, 1 = o_max_addr, 2 = done flag
   always @(negedge clk) begin
      chk_t        e;
      logic [15:0] act;
      int          lat;
      if (chk_vld_d) begin
         n_vec++;
         if (chk_q.size() == 0) begin
            n_miss++;
            $display("FAIL scoreboard_underflow got=output exp=queued_entry");
         end else begin
            e = chk_q.pop_front();
            case (e.kind)
               0:       act = o_instr_read;
               1:       act = {8'h00, o_max_addr};
               default: act = {15'h0, o_done};
            endcase
            if (act !== e.exp) begin
               n_miss++;
               $display("FAIL %s addr=%0d got=%h exp=%h",
                        (e.kind == 0) ? "instr_read" : (e.kind == 1) ? "max_addr" : "done",
                        e.a, act, e.exp);
            end
         end
      end
      if (o_done === 1'b1 && done_prev !== 1'b1) begin
         if (done_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_done got=1 exp=0 at cycle %0d", cyc);
         end else begin
            lat = done_q.pop_front();
            if (lat >= 0) begin
               n_vec++;
               if (int'(cyc - mark) != lat) begin
                  n_miss++;
                  $display("FAIL done_latency got=%0d exp=%0d", int'(cyc - mark), lat);
               end
            end
         end
      end
      done_prev = o_done;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bit_out(input logic v);
      rx = v;
      tick(CPB);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
      bit_out(1'b0);
      for (int i = 0; i < 8; i++) bit_out(b[i]);
      bit_out(stop);
      for (int g = 0; g < gap; g++) bit_out(1'b1);
   endtask

   task automatic chk(input int kind, input int a, input logic [15:0] exp);
      chk_t e;
      e.kind = kind;
      e.a    = a;
      e.exp  = exp;
      addr   = a[7:0];
      chk_q.push_back(e);
      chk_vld = 1'b1;
      tick(1);
      chk_vld = 1'b0;
   endtask

   task automatic do_reset();
      tick(2);
      rst = 1'b1;
      rx  = 1'b1;
      tick(4);
      rst = 1'b0;
      tick(2);
   endtask

   task automatic wait_done(input int limit);
      int n;
      n = 0;
      while (o_done !== 1'b1 && n < limit) begin
         tick(1);
         n++;
      end
      if (o_done !== 1'b1) begin
         n_vec++;
         n_miss++;
         $display("FAIL done_timeout got=%b exp=1", o_done);
         done_q.delete();
      end
      tick(2);
   endtask

   initial begin
      logic [8:0] nv;
      rst  = 1'b1;
      rx   = 1'b0;
      addr = '0;
      tick(5);
      chk(2, 0, 16'h0000);
      chk(1, 0, 16'h0000);
      chk(0, 0, 16'h0000);
      rx = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(2);

      // Full load: 18 bytes -> 9 words
      send_byte(8'hA5, 1'b1, 3);
      send_byte(8'h5A, 1'b1, 3);
      send_byte(8'h3C, 1'b1, 3);
      send_byte(8'h2B, 1'b1, 3);
      for (int i = 0; i < 13; i++) send_byte(8'h10, 1'b1, 3);
      send_byte(8'h10, 1'b1, 0);
      // Stop bit sampled one clock before its last cycle; done follows 80 clocks after that sample
      mark = cyc;
      done_q.push_back(IDLE_TICKS - 1);
      chk(2, 0, 16'h0000);
      chk(1, 0, 16'h0008);
      wait_done(200);
      chk(0, 8, 16'h1010);
      chk(0, 0, 16'hA55A);
      chk(0, 1, 16'h3C2B);
      chk(0, 2, 16'h1010);
      chk(0, 9, 16'h0000);
      chk(2, 0, 16'h0001);

      // Framing error on first byte
      do_reset();
      send_byte(8'h12, 1'b0, 3);
      send_byte(8'h34, 1'b1, 1);
      send_byte(8'h56, 1'b1, 0);
      done_q.push_back(-1);
      wait_done(200);
      chk(0, 0, 16'h3456);
      chk(1, 0, 16'h0000);
      chk(0, 1, 16'h3C2B);

      // Odd byte count, then traffic after done is ignored
      do_reset();
      chk(2, 0, 16'h0000);
      send_byte(8'hAB, 1'b1, 1);
      send_byte(8'hCD, 1'b1, 1);
      send_byte(8'hEF, 1'b1, 0);
      done_q.push_back(-1);
      wait_done(200);
      chk(0, 0, 16'hABCD);
      chk(0, 1, 16'h3C2B);
      chk(1, 0, 16'h0000);
      chk(2, 0, 16'h0001);
      send_byte(8'h77, 1'b1, 1);
      send_byte(8'h88, 1'b1, 1);
      chk(0, 1, 16'h3C2B);
      chk(1, 0, 16'h0000);

      // Short low glitch must not start a byte
      do_reset();
      rx = 1'b0;
      tick(2);
      rx = 1'b1;
      tick(12 * CPB);
      chk(2, 0, 16'h0000);
      send_byte(8'h11, 1'b1, 1);
      send_byte(8'h22, 1'b1, 0);
      done_q.push_back(-1);
      tick(2);
      chk(0, 0, 16'h1122);
      chk(1, 0, 16'h0000);
      wait_done(200);

      // Overflow: 257 words, word n = {0x54 | n[8], n[7:0]} lands at n-1
      do_reset();
      for (int n = 1; n <= 257; n++) begin
         nv = n[8:0];
         send_byte({7'h2A, nv[8]}, 1'b1, 1);
         send_byte(nv[7:0], 1'b1, (n == 257) ? 0 : 1);
      end
      done_q.push_back(-1);
      wait_done(200);
      chk(0, 255, 16'h5500);
      chk(0, 254, 16'h54FF);
      chk(0, 0, 16'h5401);
      chk(1, 0, 16'h00FF);
      chk(2, 0, 16'h0001);

      tick(3);
      if (chk_q.size() != 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", chk_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
